// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ID/EX control-field bit positions, ALUOp encodings,
// opcodes and the ID/EX pipeline register layout.
package cpu_pkg;

  localparam int CTRL_W = 8;

  // Bit positions inside the packed decoder control byte
  localparam int CTRL_REG_WRITE = 7;
  localparam int CTRL_MEM_REG   = 6;
  localparam int CTRL_MEM_READ  = 5;
  localparam int CTRL_MEM_WRITE = 4;
  localparam int CTRL_ALU_OP_HI = 3;
  localparam int CTRL_ALU_OP_LO = 2;
  localparam int CTRL_ALU_SRC   = 1;
  localparam int CTRL_BRANCH    = 0;

  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,  // I-type, load, store
    ALU_OP_SUB   = 2'b01,  // beq compare
    ALU_OP_RTYPE = 2'b10   // R-type, also NoOp
  } alu_op_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [31:0]       rs1_data;
    logic [31:0]       rs2_data;
    logic [31:0]       imm;
    logic [9:0]        funct;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
  } id_ex_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard check between the EX-stage load and the
// instruction currently in decode.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic       id_valid,
  input  logic       id_alu_src,
  input  logic       id_mem_write,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  output logic       hazard
);

  logic rs1_match, rs2_match, rs2_used;

  assign rs1_match = (ex_rd_addr == id_rs1_addr);
  assign rs2_match = (ex_rd_addr == id_rs2_addr);
  // rs2 matters for register-operand ALU ops and as store data
  assign rs2_used  = ~id_alu_src | id_mem_write;

  assign hazard = ex_valid & ex_mem_read & (ex_rd_addr != 5'd0) & id_valid &
                  (rs1_match | (rs2_match & rs2_used));

endmodule

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with bubble insertion and a saturating bubble count.
// Define LOAD_USE_DETECT_EN to enable load-use stall generation.
module id_ex_pipe
  import cpu_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [31:0]       rs1_data_i,
  input  logic [31:0]       rs2_data_i,
  input  logic [31:0]       imm_i,
  input  logic [9:0]        funct_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  input  logic [4:0]        rd_addr_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [31:0]       rs1_data_o,
  output logic [31:0]       rs2_data_o,
  output logic [31:0]       imm_o,
  output logic [9:0]        funct_o,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
  output logic [4:0]        rd_addr_o,
  output logic              stall_o,
  output logic [15:0]       bubble_cnt_o
);

  id_ex_t      ex_q, ex_d;
  logic [15:0] bubble_cnt_q;
  logic        stall, bubble;

`ifdef LOAD_USE_DETECT_EN
  logic hazard;

  hazard_detect u_hazard (
    .ex_valid     (ex_q.valid),
    .ex_mem_read  (ex_q.ctrl[CTRL_MEM_READ]),
    .ex_rd_addr   (ex_q.rd_addr),
    .id_valid     (valid_i),
    .id_alu_src   (ctrl_i[CTRL_ALU_SRC]),
    .id_mem_write (ctrl_i[CTRL_MEM_WRITE]),
    .id_rs1_addr  (rs1_addr_i),
    .id_rs2_addr  (rs2_addr_i),
    .hazard       (hazard)
  );

  // Flush wins: the decode instruction is dead, so holding IF/ID is pointless
  assign stall = hazard & ~flush_i;
`else
  assign stall = 1'b0;
`endif

  assign bubble = stall | flush_i;

  always_comb begin
    ex_d = '0;
    if (!bubble && valid_i) begin
      ex_d.valid    = 1'b1;
      ex_d.ctrl     = ctrl_i;
      ex_d.rs1_data = rs1_data_i;
      ex_d.rs2_data = rs2_data_i;
      ex_d.imm      = imm_i;
      ex_d.funct    = funct_i;
      ex_d.rs1_addr = rs1_addr_i;
      ex_d.rs2_addr = rs2_addr_i;
      ex_d.rd_addr  = rd_addr_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_q <= ex_d;
      if (bubble && bubble_cnt_q != 16'hFFFF)
        bubble_cnt_q <= bubble_cnt_q + 16'd1;
    end
  end

  assign valid_o      = ex_q.valid;
  assign ctrl_o       = ex_q.ctrl;
  assign rs1_data_o   = ex_q.rs1_data;
  assign rs2_data_o   = ex_q.rs2_data;
  assign imm_o        = ex_q.imm;
  assign funct_o      = ex_q.funct;
  assign rs1_addr_o   = ex_q.rs1_addr;
  assign rs2_addr_o   = ex_q.rs2_addr;
  assign rd_addr_o    = ex_q.rd_addr;
  assign stall_o      = stall;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe: directed load-use/flush/saturation
// scenarios plus randomized traffic against a behavioural model.
module tb_id_ex_pipe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, flush_i;
  logic [7:0]  ctrl_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i;
  logic [9:0]  funct_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic        valid_o;
  logic [7:0]  ctrl_o;
  logic [31:0] rs1_data_o, rs2_data_o, imm_o;
  logic [9:0]  funct_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic        stall_o;
  logic [15:0] bubble_cnt_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  id_ex_pipe dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .flush_i(flush_i),
    .ctrl_i(ctrl_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
    .imm_i(imm_i), .funct_i(funct_i), .rs1_addr_i(rs1_addr_i),
    .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i), .valid_o(valid_o),
    .ctrl_o(ctrl_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .imm_o(imm_o), .funct_o(funct_o), .rs1_addr_o(rs1_addr_o),
    .rs2_addr_o(rs2_addr_o), .rd_addr_o(rd_addr_o), .stall_o(stall_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Model of what the EX stage should hold: one record per cycle plus a counter
  typedef struct {
    bit          v;
    bit [7:0]    ctrl;
    bit [31:0]   d1, d2, imm;
    bit [9:0]    funct;
    bit [4:0]    a1, a2, rd;
  } ex_rec_t;

  ex_rec_t m;
  int      m_cnt;

  function automatic bit model_stall();
    bit is_load_in_ex, uses_rs2;
`ifdef LOAD_USE_DETECT_EN
    is_load_in_ex = m.v && m.ctrl[5] && (m.rd != 0);
    uses_rs2      = (ctrl_i[1] == 0) || (ctrl_i[4] == 1);
    return is_load_in_ex && valid_i && !flush_i &&
           ((m.rd == rs1_addr_i) || (m.rd == rs2_addr_i && uses_rs2));
`else
    is_load_in_ex = 0;
    uses_rs2      = 0;
    return is_load_in_ex | uses_rs2;
`endif
  endfunction

  always @(posedge clk_i) begin
    bit st;
    st = model_stall();
    if (rst_i) begin
      m     = '{default: 0};
      m_cnt = 0;
    end else begin
      if (st || flush_i || !valid_i)
        m = '{default: 0};
      else
        m = '{v: 1, ctrl: ctrl_i, d1: rs1_data_i, d2: rs2_data_i, imm: imm_i,
              funct: funct_i, a1: rs1_addr_i, a2: rs2_addr_i, rd: rd_addr_i};
      if ((st || flush_i) && m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("valid_o", {63'd0, valid_o}, {63'd0, m.v});
      chk("ctrl_o", {56'd0, ctrl_o}, {56'd0, m.ctrl});
      chk("rs1_data_o", {32'd0, rs1_data_o}, {32'd0, m.d1});
      chk("rs2_data_o", {32'd0, rs2_data_o}, {32'd0, m.d2});
      chk("imm_o", {32'd0, imm_o}, {32'd0, m.imm});
      chk("funct_o", {54'd0, funct_o}, {54'd0, m.funct});
      chk("addr_o", {49'd0, rs1_addr_o, rs2_addr_o, rd_addr_o},
          {49'd0, m.a1, m.a2, m.rd});
      chk("stall_o", {63'd0, stall_o}, {63'd0, model_stall()});
      chk("bubble_cnt_o", {48'd0, bubble_cnt_o}, 64'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_instr(input bit v, input bit [7:0] c, input bit [4:0] r1,
                           input bit [4:0] r2, input bit [4:0] rd);
    valid_i    = v;
    ctrl_i     = c;
    rs1_addr_i = r1;
    rs2_addr_i = r2;
    rd_addr_i  = rd;
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    imm_i      = $urandom;
    funct_i    = 10'($urandom);
  endtask

  localparam bit [7:0] LW   = 8'hE2;
  localparam bit [7:0] ADD  = 8'h88;
  localparam bit [7:0] ADDI = 8'h82;

  initial begin
    int c0;
    rst_i   = 1;
    flush_i = 0;
    set_instr(0, 0, 0, 0, 0);
    step();
    step();
    rst_i = 0;
    step();
    cmp_en = 1;
    #1;
    chk("reset valid_o", {63'd0, valid_o}, 0);
    chk("reset ctrl_o", {56'd0, ctrl_o}, 0);
    chk("reset rd_addr_o", {59'd0, rd_addr_o}, 0);
    chk("reset stall_o", {63'd0, stall_o}, 0);
    chk("reset bubble_cnt", {48'd0, bubble_cnt_o}, 0);

    // lw x5 then add x6,x5,x7
    set_instr(1, LW, 5'd1, 5'd0, 5'd5);
    step();
    set_instr(1, ADD, 5'd5, 5'd7, 5'd6);
    #1;
`ifdef LOAD_USE_DETECT_EN
    chk("loaduse stall", {63'd0, stall_o}, 1);
    step();
    #1;
    chk("bubble valid_o", {63'd0, valid_o}, 0);
    chk("bubble ctrl_o", {56'd0, ctrl_o}, 0);
    chk("bubble count", {48'd0, bubble_cnt_o}, 1);
    chk("stall one cycle", {63'd0, stall_o}, 0);
    step();
    #1;
`else
    chk("no-detect stall", {63'd0, stall_o}, 0);
    step();
    #1;
    chk("no-detect count", {48'd0, bubble_cnt_o}, 0);
`endif
    chk("add valid_o", {63'd0, valid_o}, 1);
    chk("add rd_addr_o", {59'd0, rd_addr_o}, 6);
    chk("add ctrl_o", {56'd0, ctrl_o}, {56'd0, ADD});

    // lw x0 then use of x0: never a hazard
    set_instr(1, LW, 5'd1, 5'd0, 5'd0);
    step();
    set_instr(1, ADD, 5'd0, 5'd0, 5'd6);
    #1;
    chk("x0 stall", {63'd0, stall_o}, 0);
    // lw x5 then addi x6,x7,4 whose rs2 field happens to be 5
    set_instr(1, LW, 5'd1, 5'd0, 5'd5);
    step();
    set_instr(1, ADDI, 5'd7, 5'd5, 5'd6);
    #1;
    chk("addi rs2 stall", {63'd0, stall_o}, 0);

    // load-use pair with flush in the hazard cycle
    set_instr(1, LW, 5'd1, 5'd0, 5'd5);
    step();
    set_instr(1, ADD, 5'd5, 5'd7, 5'd6);
    flush_i = 1;
    #1;
    chk("flush stall", {63'd0, stall_o}, 0);
    c0 = int'(bubble_cnt_o);
    step();
    flush_i = 0;
    set_instr(0, 0, 0, 0, 0);
    #1;
    chk("flush bubble valid", {63'd0, valid_o}, 0);
    chk("flush count", {48'd0, bubble_cnt_o}, 64'(c0 + 1));

    // randomized traffic with a small register space to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      bit [7:0] c;
      c = 8'($urandom);
      if ($urandom_range(0, 2) == 0) c[5] = 1;
      set_instr($urandom_range(0, 9) < 8, c, 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      flush_i = ($urandom_range(0, 9) == 0);
      rst_i   = ($urandom_range(0, 99) == 0);
      step();
    end

    // counter saturation via flushes
    rst_i   = 1;
    flush_i = 0;
    step();
    rst_i   = 0;
    flush_i = 1;
    set_instr(0, 0, 0, 0, 0);
    for (int i = 0; i < 65534; i++) step();
    #1;
    chk("count FFFE", {48'd0, bubble_cnt_o}, 64'hFFFE);
    step();
    #1;
    chk("count FFFF", {48'd0, bubble_cnt_o}, 64'hFFFF);
    step();
    step();
    step();
    #1;
    chk("count saturated", {48'd0, bubble_cnt_o}, 64'hFFFF);
    flush_i = 0;
    step();
    step();

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
